// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter. Requester indices are sized for the
// largest supported requester count (16) so one type serves every instance.
package bram_arb_pkg;

    localparam int MAX_REQ              = 16;
    localparam int DEFAULT_READ_LATENCY = 5;

    typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t idx;
    } tag_t;

    // Round-robin successor of idx among n requesters.
    function automatic req_idx_t next_ptr(input req_idx_t idx, input int n);
        return (int'(idx) >= n - 1) ? req_idx_t'(0) : idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request found searching
// circularly upward from ptr.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  req_idx_t     ptr,
    output logic [N-1:0] grant,
    output req_idx_t     grant_idx,
    output logic         any
);

    localparam int           IW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    int            sum_s;
    logic [IW-1:0] pos_s;

    // Scan from the farthest candidate back to ptr so the nearest request overwrites the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum_s     = 0;
        pos_s     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum_s     = (int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
            pos_s     = IW'(sum_s);
            grant     = req[pos_s] ? (ONE << pos_s) : grant;
            grant_idx = req[pos_s] ? req_idx_t'(pos_s) : grant_idx;
            any       = any | req[pos_s];
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NUM_REQ requesters; read results are routed back
// to their requester READ_LATENCY cycles after acceptance via a tag pipeline.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy,
    output logic                          bram_en,
    output logic                          bram_we,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [DATA_WIDTH-1:0]         bram_din,
    output logic                          bram_rst,
    input  logic [DATA_WIDTH-1:0]         bram_dout
);

    logic [NUM_REQ-1:0] req_masked_s;
    logic [NUM_REQ-1:0] grant_s;
    req_idx_t           grant_idx_s;
    logic               any_s;
    req_idx_t           rr_ptr_r;
    tag_t               tag_r [READ_LATENCY];
    logic               busy_s;

    // Hide requests during reset so nothing can be accepted.
    always_comb begin
        req_masked_s = rst ? '0 : req_valid;
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req       (req_masked_s),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    assign req_ready = grant_s;
    assign bram_rst  = rst;
    assign rsp_data  = bram_dout;

    // AND-OR mux of the granted command; an empty grant leaves everything zero.
    always_comb begin
        bram_en   = any_s;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bram_we   = bram_we | (grant_s[i] & req_we[i]);
            bram_addr = bram_addr | ({ADDR_WIDTH{grant_s[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
            bram_din  = bram_din | ({DATA_WIDTH{grant_s[i]}} & req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Round-robin pointer moves past the winner only on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (any_s) begin
            rr_ptr_r <= next_ptr(grant_idx_s, NUM_REQ);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag shift register tracking which requester owns each in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                tag_r[s] <= '0;
            end
        end else begin
            tag_r[0].valid <= any_s & ~bram_we;
            tag_r[0].idx   <= grant_idx_s;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_r[s] <= tag_r[s-1];
            end
        end
    end

    // Response strobe and busy decode; both held low while reset is asserted.
    always_comb begin
        busy_s = 1'b0;
        for (int s = 0; s < READ_LATENCY; s++) begin
            busy_s = busy_s | tag_r[s].valid;
        end
        busy      = busy_s & ~rst;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tag_r[READ_LATENCY-1].valid & ~rst &
                           (tag_r[READ_LATENCY-1].idx == req_idx_t'(i));
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: a 5-cycle write-first BRAM model drives bram_dout, and a
// queue-based reference model predicts grants, commands and read returns.
module tb_bram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int RL = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_data, bram_din, bram_dout;
    logic          busy, bram_en, bram_we, bram_rst;
    logic [AW-1:0] bram_addr;

    always #5 clk = ~clk;

    bram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_rst(bram_rst), .bram_dout(bram_dout)
    );

    function automatic logic [DW-1:0] pre(input int a);
        return 64'hA5A5_0000_0000_0000 | (64'(a) * 64'h0000_0001_0000_0101);
    endfunction

    // BRAM model: unwritten words read back as the preload pattern.
    logic [DW-1:0] mem [1024];
    bit            written [1024];
    logic [DW-1:0] pipe [RL];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr]     <= bram_din;
                written[bram_addr] <= 1'b1;
                pipe[0]            <= bram_din;
            end else begin
                pipe[0] <= written[bram_addr] ? mem[bram_addr] : pre(int'(bram_addr));
            end
        end
        for (int s = 1; s < RL; s++) pipe[s] <= pipe[s-1];
    end
    assign bram_dout = pipe[RL-1];

    // Reference model state
    typedef struct { int due; int idx; logic [DW-1:0] data; } exp_t;
    exp_t          m_q[$];
    logic [DW-1:0] ref_mem [int];
    int            m_ptr = 0;
    int            cyc = 0;
    int            n_vec = 0, n_err = 0;
    int            rsp_count = 0;
    int            last_grant;
    logic [N-1:0]  last_ready, last_rsp;
    logic [DW-1:0] last_data;
    logic          last_busy;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : pre(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input int a, input logic [DW-1:0] d);
        req_valid[i]             = v;
        req_we[i]                = we;
        req_addr[i*AW +: AW]     = AW'(a);
        req_wdata[i*DW +: DW]    = d;
    endtask

    task automatic clear_all();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    // One clock cycle: compare everything against the model, then advance the model.
    task automatic step();
        int            gi, p;
        logic [N-1:0]  eg, ev;
        bit            w, is_due;
        int            a;
        logic [DW-1:0] wd;
        @(negedge clk);
        gi = -1;
        eg = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (gi < 0 && req_valid[p]) gi = p;
            end
        end
        if (gi >= 0) begin
            eg[gi] = 1'b1;
            w  = req_we[gi];
            a  = int'(req_addr[gi*AW +: AW]);
            wd = req_wdata[gi*DW +: DW];
        end else begin
            w = 1'b0; a = 0; wd = '0;
        end
        is_due = !rst && m_q.size() > 0 && m_q[0].due == cyc;
        ev = is_due ? (4'b0001 << m_q[0].idx) : 4'b0000;
        chk("req_ready", 64'(req_ready), 64'(eg));
        chk("bram_en", 64'(bram_en), 64'(gi >= 0));
        chk("bram_we", 64'(bram_we), 64'(w));
        chk("bram_addr", 64'(bram_addr), 64'(a));
        chk("bram_din", bram_din, wd);
        chk("bram_rst", 64'(bram_rst), 64'(rst));
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("busy", 64'(busy), 64'(!rst && m_q.size() > 0));
        if (is_due) chk("rsp_data", rsp_data, m_q[0].data);
        last_grant = gi; last_ready = req_ready; last_rsp = rsp_valid;
        last_data = rsp_data; last_busy = busy;
        if (rsp_valid != 4'b0000) rsp_count++;
        if (is_due) void'(m_q.pop_front());
        if (rst) begin
            m_q.delete();
            m_ptr = 0;
        end else if (gi >= 0) begin
            m_ptr = (gi + 1) % N;
            if (w) ref_mem[a] = wd;
            else   m_q.push_back('{due: cyc + RL, idx: gi, data: ref_rd(a)});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        clear_all();
        for (int k = 0; k < n; k++) step();
    endtask

    typedef struct { logic [N-1:0] valid; logic [N-1:0] exp_ready; logic exp_en; } vec_t;
    vec_t tbl [12];

    initial begin
        int base, acc;
        logic [N-1:0] one, expg;
        tbl[0]  = '{4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0001, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0010, 1'b1};
        tbl[3]  = '{4'b1010, 4'b1000, 1'b1};
        tbl[4]  = '{4'b0110, 4'b0010, 1'b1};
        tbl[5]  = '{4'b0011, 4'b0001, 1'b1};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0};
        tbl[7]  = '{4'b1111, 4'b0010, 1'b1};
        tbl[8]  = '{4'b1001, 4'b1000, 1'b1};
        tbl[9]  = '{4'b0101, 4'b0001, 1'b1};
        tbl[10] = '{4'b0101, 4'b0100, 1'b1};
        tbl[11] = '{4'b0001, 4'b0001, 1'b1};
        one = 4'b0001;

        // Reset with every requester asserting: nothing may be granted.
        clear_all();
        rst = 1'b1;
        req_valid = 4'b1111;
        @(posedge clk); #1;
        step();
        step();
        chk("reset_ready", 64'(last_ready), 64'(4'b0000));
        chk("reset_busy", 64'(last_busy), 64'(1'b0));
        rst = 1'b0;
        clear_all();

        // Arbitration table (writes only, so no responses are generated).
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) set_req(i, tbl[r].valid[i], 1'b1, 12'h300 + i * 16 + r, {$urandom, $urandom});
            step();
            chk("tbl_ready", 64'(last_ready), 64'(tbl[r].exp_ready));
            chk("tbl_en", 64'(last_grant >= 0), 64'(tbl[r].exp_en));
        end
        clear_all();

        // Single reader: write then read back 3 cycles later.
        set_req(2, 1'b1, 1'b1, 16'h10, 64'h0000_0000_DEAD_BEEF);
        step();
        chk("single_wr_grant", 64'(last_ready), 64'(4'b0100));
        idle(2);
        set_req(2, 1'b1, 1'b0, 16'h10, 64'h0);
        step();
        chk("single_rd_grant", 64'(last_ready), 64'(4'b0100));
        idle(4);
        chk("single_rsp_early", 64'(last_rsp), 64'(4'b0000));
        step();
        chk("single_rsp_valid", 64'(last_rsp), 64'(4'b0100));
        chk("single_rsp_data", last_data, 64'h0000_0000_DEAD_BEEF);

        // Full contention: all four hold reads of addrs 0..3.
        do_reset();
        base = rsp_count;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, i, 64'h0);
        for (int c = 0; c < 8; c++) begin
            step();
            expg = one << (c % N);
            chk("contend_grant", 64'(last_ready), 64'(expg));
        end
        idle(RL + 1);
        chk("contend_rsp_count", 64'(rsp_count - base), 64'(8));

        // Back-to-back reads from requester 0 alone.
        base = rsp_count;
        for (int c = 0; c < 16; c++) begin
            set_req(0, 1'b1, 1'b0, c, 64'h0);
            step();
            chk("b2b_grant", 64'(last_ready), 64'(4'b0001));
        end
        idle(RL + 1);
        chk("b2b_rsp_count", 64'(rsp_count - base), 64'(16));

        // Mixed: requester 1 writes addr 5, requester 3 then reads it.
        do_reset();
        base = rsp_count;
        set_req(1, 1'b1, 1'b1, 5, 64'hA5);
        set_req(3, 1'b1, 1'b0, 5, 64'h0);
        step();
        chk("mixed_wr_grant", 64'(last_ready), 64'(4'b0010));
        set_req(1, 1'b0, 1'b0, 0, 64'h0);
        step();
        chk("mixed_rd_grant", 64'(last_ready), 64'(4'b1000));
        idle(RL - 1);
        chk("mixed_rsp_early", 64'(last_rsp), 64'(4'b0000));
        step();
        chk("mixed_rsp_valid", 64'(last_rsp), 64'(4'b1000));
        chk("mixed_rsp_data", last_data, 64'hA5);
        idle(3);
        chk("mixed_rsp_count", 64'(rsp_count - base), 64'(1));

        // Reset with three reads in flight.
        for (int c = 0; c < 3; c++) begin
            set_req(0, 1'b1, 1'b0, 20 + c, 64'h0);
            step();
        end
        rst = 1'b1;
        step();
        chk("midrst_ready", 64'(last_ready), 64'(4'b0000));
        rst = 1'b0;
        base = rsp_count;
        clear_all();
        step();
        chk("midrst_busy", 64'(last_busy), 64'(1'b0));
        idle(7);
        chk("midrst_no_rsp", 64'(rsp_count - base), 64'(0));
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 40 + i, 64'h0);
        step();
        chk("midrst_ptr_restart", 64'(last_ready), 64'(4'b0001));
        idle(RL + 1);

        // Randomized traffic with occasional reset; requests held until accepted.
        acc = 0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_grant == i) begin
                    set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                            $urandom_range(0, 31), {$urandom, $urandom});
                end
            end
            step();
            if (last_grant >= 0) acc++;
        end
        rst = 1'b0;
        idle(RL + 2);
        chk("random_activity", 64'(acc > 100), 64'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
